// File: rtl/drum_poll_pkg.sv
// Shared register map, field offsets and event-word layout for the drum pad scheduler.
// With DRUM_TIMESTAMP_EN defined, each stored event also carries a 16-bit timestamp.
package drum_poll_pkg;

    localparam logic [1:0] ADDR_EVENT  = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;
    localparam int CTRL_DIV_LSB   = 16;
    localparam int STATUS_DEB_LSB = 8;
    localparam int STATUS_OVF_BIT = 24;

    localparam int EVT_IDX_W = 8;
    localparam int EVT_TS_W  = 16;
`ifdef DRUM_TIMESTAMP_EN
    localparam int EVT_W = EVT_IDX_W + EVT_TS_W;
`else
    localparam int EVT_W = EVT_IDX_W;
`endif

    typedef struct packed {
        logic [EVT_TS_W-1:0]  ts;
        logic [6:0]           rsvd;
        logic                 valid;
        logic [EVT_IDX_W-1:0] idx;
    } evt_word_t;

endpackage

// File: rtl/drum_evt_fifo.sv
// Synchronous event FIFO with push, pop and flush; flush wins over both.
// DEPTH must be a power of two so the pointers wrap by overflow.
module drum_evt_fifo
    import drum_poll_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == {(AW+1){1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop_s  = pop_i && !flush_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            wr_ptr_d = do_push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/drum_hit_scheduler.sv
// Drum pad scanner: prescaled sampling, per-pad debounce, round-robin hit arbitration
// into an event FIFO, Avalon-MM register access. Optional timestamps: DRUM_TIMESTAMP_EN.
module drum_hit_scheduler
    import drum_poll_pkg::*;
#(
    parameter int          NUM_PADS    = 8,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DEB_SAMPLES = 4,
    parameter logic [15:0] DIV_RESET   = 16'h00FF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read_n,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    input  logic [NUM_PADS-1:0] in_port,
    output logic [31:0]         readdata,
    output logic                irq
);

    localparam int PTR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                   enable_q, enable_d, overflow_q, overflow_d, irq_q, irq_d;
    logic [NUM_PADS-1:0]    mask_q, mask_d, pending_q, pending_d, deb_q, deb_d;
    logic [15:0]            scan_div_q, scan_div_d, presc_q, presc_d;
    logic [PTR_W-1:0]       rr_q, rr_d, grant_idx_s;
    logic [31:0]            readdata_q, readdata_d;
    logic [DEB_SAMPLES-1:0] hist_q [NUM_PADS];
    logic [DEB_SAMPLES-1:0] hist_d [NUM_PADS];

    logic                   rd_en_s, wr_en_s, ctrl_wr_s, flush_s, pop_s, tick_s;
    logic                   grant_v_s, push_req_s, drop_s, fifo_full_s, fifo_empty_s;
    logic [NUM_PADS-1:0]    hit_s, rot_s, grant_oh_s;
    logic [2*NUM_PADS-1:0]  dbl_s;
    logic [PTR_W:0]         sum_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic [EVT_W-1:0]       fifo_din_s, fifo_dout_s;
    evt_word_t              evt_word_s;
    logic                   unused_s;

    assign rd_en_s    = chipselect && !read_n;
    assign wr_en_s    = chipselect && !write_n;
    assign ctrl_wr_s  = wr_en_s && (address == ADDR_CTRL);
    assign flush_s    = ctrl_wr_s && writedata[CTRL_FLUSH_BIT];
    assign pop_s      = rd_en_s && (address == ADDR_EVENT) && !fifo_empty_s;
    assign tick_s     = enable_q && (presc_q == scan_div_q);
    assign push_req_s = grant_v_s && enable_q;
    assign drop_s     = push_req_s && !flush_s && fifo_full_s && !pop_s;
    assign readdata   = readdata_q;
    assign irq        = irq_q;
    assign unused_s   = ^{writedata, dbl_s[2*NUM_PADS-1:NUM_PADS]};

    // Rotating the pending vector by rr puts the search start at bit 0.
    assign dbl_s      = {pending_q, pending_q} >> rr_q;
    assign rot_s      = dbl_s[NUM_PADS-1:0];
    assign grant_oh_s = grant_v_s ? (NUM_PADS'(1'b1) << grant_idx_s) : {NUM_PADS{1'b0}};

    // Round-robin arbiter: first pending pad at or above rr, with wrap.
    always_comb begin
        grant_v_s   = 1'b0;
        grant_idx_s = {PTR_W{1'b0}};
        sum_s       = {(PTR_W+1){1'b0}};
        for (int k = 0; k < NUM_PADS; k++) begin
            if (!grant_v_s && rot_s[k]) begin
                grant_v_s = 1'b1;
                sum_s     = {1'b0, rr_q} + (PTR_W+1)'(k);
                if (sum_s >= (PTR_W+1)'(NUM_PADS)) begin
                    sum_s = sum_s - (PTR_W+1)'(NUM_PADS);
                end else begin
                    sum_s = sum_s;
                end
                grant_idx_s = sum_s[PTR_W-1:0];
            end else begin
                grant_v_s = grant_v_s;
            end
        end
    end

    // Debounce: state flips only once the whole sample history agrees.
    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            hist_d[i] = hist_q[i];
            deb_d[i]  = deb_q[i];
            if (tick_s) begin
                hist_d[i] = (hist_q[i] << 1) | DEB_SAMPLES'(in_port[i]);
                if (&hist_d[i]) begin
                    deb_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    deb_d[i] = 1'b0;
                end else begin
                    deb_d[i] = deb_q[i];
                end
            end else begin
                hist_d[i] = hist_q[i];
            end
        end
    end

    assign hit_s = deb_d & ~deb_q & mask_q;

    // Control registers, prescaler, pending set, rr pointer, overflow and irq.
    always_comb begin
        enable_d   = enable_q;
        scan_div_d = scan_div_q;
        mask_d     = mask_q;
        presc_d    = presc_q;
        rr_d       = rr_q;
        overflow_d = overflow_q;
        if (ctrl_wr_s) begin
            enable_d   = writedata[CTRL_EN_BIT];
            scan_div_d = writedata[CTRL_DIV_LSB +: 16];
            presc_d    = 16'd0;
        end else if (tick_s) begin
            presc_d    = 16'd0;
        end else if (enable_q) begin
            presc_d    = presc_q + 16'd1;
        end else begin
            presc_d    = presc_q;
        end
        if (wr_en_s && (address == ADDR_MASK)) begin
            mask_d = writedata[NUM_PADS-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (push_req_s) begin
            rr_d = (grant_idx_s == PTR_W'(NUM_PADS - 1)) ? {PTR_W{1'b0}}
                                                         : grant_idx_s + PTR_W'(1);
        end else begin
            rr_d = rr_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (wr_en_s && (address == ADDR_STATUS) && writedata[STATUS_OVF_BIT]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (!enable_q || flush_s) begin
            pending_d = {NUM_PADS{1'b0}};
        end else begin
            pending_d = (pending_q & ~grant_oh_s) | hit_s;
        end
        irq_d = enable_q && (fifo_count_s != {CNT_W{1'b0}});
    end

    // EVENT word view of the FIFO head; an empty FIFO reads as all zeros.
    always_comb begin
        evt_word_s = evt_word_t'(32'h0);
        if (!fifo_empty_s) begin
            evt_word_s.valid = 1'b1;
            evt_word_s.idx   = fifo_dout_s[EVT_IDX_W-1:0];
`ifdef DRUM_TIMESTAMP_EN
            evt_word_s.ts    = fifo_dout_s[EVT_W-1:EVT_IDX_W];
`endif
        end else begin
            evt_word_s.valid = 1'b0;
        end
    end

    // Registered read mux.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en_s) begin
            case (address)
                ADDR_EVENT:  readdata_d = evt_word_s;
                ADDR_STATUS: readdata_d = {7'd0, overflow_q, 16'(deb_q), 3'd0, 5'(fifo_count_s)};
                ADDR_MASK:   readdata_d = 32'(mask_q);
                ADDR_CTRL:   readdata_d = {scan_div_q, 14'd0, 1'b0, enable_q};
                default:     readdata_d = 32'h0;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

`ifdef DRUM_TIMESTAMP_EN
    logic [EVT_TS_W-1:0] ts_q;
    assign fifo_din_s = {ts_q, EVT_IDX_W'(grant_idx_s)};

    // Free-running timestamp, advances only while scanning is enabled.
    always_ff @(posedge clk) begin
        if (reset) ts_q <= 16'd0;
        else       ts_q <= enable_q ? ts_q + 16'd1 : ts_q;
    end
`else
    assign fifo_din_s = EVT_IDX_W'(grant_idx_s);
`endif

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q   <= 1'b0;
            scan_div_q <= DIV_RESET;
            mask_q     <= {NUM_PADS{1'b0}};
            presc_q    <= 16'd0;
            rr_q       <= {PTR_W{1'b0}};
            overflow_q <= 1'b0;
            pending_q  <= {NUM_PADS{1'b0}};
            deb_q      <= {NUM_PADS{1'b0}};
            irq_q      <= 1'b0;
            readdata_q <= 32'h0;
            for (int i = 0; i < NUM_PADS; i++) hist_q[i] <= {DEB_SAMPLES{1'b0}};
        end else begin
            enable_q   <= enable_d;
            scan_div_q <= scan_div_d;
            mask_q     <= mask_d;
            presc_q    <= presc_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
            deb_q      <= deb_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < NUM_PADS; i++) hist_q[i] <= hist_d[i];
        end
    end

    drum_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_req_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .data_i  (fifo_din_s),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

endmodule

// File: tb/tb_drum_hit_scheduler.sv
// Self-checking bench for drum_hit_scheduler: directed scenarios plus randomized traffic
// against a behavioural model built on run-length counters and a queue.
module tb_drum_hit_scheduler;

    localparam int NP    = 8;
    localparam int DEPTH = 8;
    localparam int DEB   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    drum_hit_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit          m_en, m_ovf, m_irq;
    bit [7:0]    m_mask, m_pend, m_deb;
    int unsigned m_div, m_presc, m_ts;
    int          m_rr;
    int          m_ones [NP];
    int          m_zeros[NP];
    int unsigned m_fifo[$];
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_en = 0; m_ovf = 0; m_irq = 0; m_mask = 0; m_pend = 0; m_deb = 0;
        m_div = 255; m_presc = 0; m_ts = 0; m_rr = 0; m_rdata = 32'h0;
        m_fifo.delete();
        for (int i = 0; i < NP; i++) begin
            m_ones[i] = 0;
            m_zeros[i] = DEB;
        end
    endtask

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return (m_fifo.size() > 0) ? (m_fifo[0] | 32'h100) : 32'h0;
            2'd1:    return (32'(m_ovf) << 24) | (32'(m_deb) << 8) | 32'(m_fifo.size());
            2'd2:    return 32'(m_mask);
            default: return (m_div << 16) | 32'(m_en);
        endcase
    endfunction

    task automatic model_step(input bit rd, input bit wr, input logic [1:0] a,
                              input logic [31:0] wd, input logic [7:0] pads);
        int       old_size = m_fifo.size();
        bit       pop      = rd && (a == 2'd0) && (old_size > 0);
        bit       tick     = m_en && (m_presc == m_div);
        bit       flush    = wr && (a == 2'd3) && wd[1];
        bit [7:0] new_deb  = m_deb;
        bit [7:0] hit;
        int       g = -1;
        bit       push, drop;
        int unsigned word;
        if (rd) m_rdata = model_reg(a);
        if (tick) begin
            for (int i = 0; i < NP; i++) begin
                if (pads[i]) begin
                    m_ones[i] = (m_ones[i] < DEB) ? m_ones[i] + 1 : DEB;
                    m_zeros[i] = 0;
                end else begin
                    m_zeros[i] = (m_zeros[i] < DEB) ? m_zeros[i] + 1 : DEB;
                    m_ones[i] = 0;
                end
                if (m_ones[i] == DEB) new_deb[i] = 1;
                if (m_zeros[i] == DEB) new_deb[i] = 0;
            end
        end
        hit = new_deb & ~m_deb & m_mask;
        for (int k = 0; k < NP; k++)
            if (g < 0 && m_pend[(m_rr + k) % NP]) g = (m_rr + k) % NP;
        push = (g >= 0) && m_en;
`ifdef DRUM_TIMESTAMP_EN
        word = g | (m_ts << 16);
`else
        word = g;
`endif
        drop = 0;
        if (flush) begin
            m_fifo.delete();
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (push) begin
                if (old_size < DEPTH || pop) m_fifo.push_back(word);
                else drop = 1;
            end
        end
        if (drop) m_ovf = 1;
        else if (wr && a == 2'd1 && wd[24]) m_ovf = 0;
        if (push) m_rr = (g + 1) % NP;
        if (!m_en || flush) begin
            m_pend = 0;
        end else begin
            if (g >= 0) m_pend[g] = 0;
            m_pend = m_pend | hit;
        end
        if (wr && a == 2'd3) m_presc = 0;
        else if (tick) m_presc = 0;
        else if (m_en) m_presc = m_presc + 1;
        m_irq = m_en && (old_size != 0);
        if (m_en) m_ts = (m_ts + 1) & 32'hFFFF;
        m_deb = new_deb;
        if (wr && a == 2'd2) m_mask = wd[7:0];
        if (wr && a == 2'd3) begin
            m_en  = wd[0];
            m_div = wd[31:16];
        end
    endtask

    task automatic cycle();
        bit          rd = chipselect && !read_n;
        bit          wr = chipselect && !write_n;
        bit          rst = reset;
        logic [1:0]  a = address;
        logic [31:0] wd = writedata;
        logic [7:0]  p = in_port;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_step(rd, wr, a, wd, p);
        check_val("irq", 32'(irq), 32'(m_irq));
        if (rd && !rst) check_val("rdata", readdata, m_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        cycle();
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        address = a; writedata = wd; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int          guard;
        int          exp_order[3] = '{6, 1, 4};
        reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_port = 8'h00;
        idle(2);
        reset = 1'b0;

        bus_read(2'd0, d); check_val("rst_event", d, 32'h0);
        bus_read(2'd1, d); check_val("rst_status", d, 32'h0);
        bus_read(2'd2, d); check_val("rst_mask", d, 32'h0);
        bus_read(2'd3, d); check_val("rst_ctrl", d, 32'h00FF0000);
        check_val("rst_irq", 32'(irq), 32'h0);

        bus_write(2'd2, 32'hFF);
        bus_write(2'd3, 32'h1);
        in_port = 8'h08; idle(4);
        in_port = 8'h00; idle(3);
        check_val("pad3_irq_rise", 32'(irq), 32'h1);
        bus_read(2'd0, d); check_val("pad3_event", d & 32'hFFFF, 32'h103);
        idle(2);
        check_val("pad3_irq_fall", 32'(irq), 32'h0);

        in_port = 8'h20; idle(3);
        in_port = 8'h00; idle(6);
        bus_read(2'd1, d);
        check_val("glitch_deb13", 32'(d[13]), 32'h0);
        check_val("glitch_count", 32'(d[4:0]), 32'h0);

        in_port = 8'h10; idle(4);
        in_port = 8'h00; idle(4);
        bus_read(2'd0, d); check_val("pad4_event", d & 32'h1FF, 32'h104);
        idle(2);
        in_port = 8'h52; idle(4);
        in_port = 8'h00; idle(6);
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd0, d);
            check_val("rr_order", d & 32'h1FF, 32'h100 | 32'(exp_order[i]));
        end

        in_port = 8'hFF; idle(4);
        in_port = 8'h00; idle(12);
        in_port = 8'h01; idle(4);
        in_port = 8'h00; idle(8);
        bus_read(2'd1, d);
        check_val("ovf_count", 32'(d[4:0]), 32'h8);
        check_val("ovf_set", 32'(d[24]), 32'h1);
        bus_write(2'd1, 32'h01000000);
        bus_read(2'd1, d);
        check_val("ovf_clear", 32'(d[24]), 32'h0);
        check_val("ovf_count_kept", 32'(d[4:0]), 32'h8);
        bus_write(2'd3, 32'h3);
        bus_read(2'd1, d);
        check_val("flush_count", 32'(d[4:0]), 32'h0);
        check_val("flush_irq", 32'(irq), 32'h0);
        bus_read(2'd3, d); check_val("ctrl_flush_reads0", d, 32'h1);

        idle(8);
        guard = 0;
        while (m_ts != 32'h1230 && guard < 20000) begin
            cycle();
            guard++;
        end
        check_val("ts_wait", 32'(guard < 20000), 32'h1);
        in_port = 8'h01; idle(4);
        in_port = 8'h00; idle(3);
        bus_read(2'd0, d);
`ifdef DRUM_TIMESTAMP_EN
        check_val("ts_event", d, 32'h12340100);
`else
        check_val("ts_event", d, 32'h00000100);
`endif

        for (int it = 0; it < 3000; it++) begin
            int r = $urandom_range(0, 99);
            if ($urandom_range(0, 5) == 0) in_port = 8'($urandom);
            if (r < 35) begin
                bus_read(2'($urandom_range(0, 3)), d);
            end else if (r < 43) begin
                logic [1:0] a = 2'($urandom_range(0, 3));
                if (a == 2'd3)
                    bus_write(a, {16'($urandom_range(0, 2)), 14'd0,
                                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0)});
                else
                    bus_write(a, $urandom);
            end else if (r == 99 && $urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
                bus_read(2'd3, d);
                check_val("midrst_ctrl", d, 32'h00FF0000);
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
